// File: rtl/pattern_detect_mealy_fsm.sv
// pattern_detect_mealy_fsm: serial Mealy sequence detector with KMP fallback
//
// Ports:
//   clk_i              - clock, all state updates on the rising edge
//   rst_i              - asynchronous active-low reset, forces S0 and masks the flag
//   d_i                - serial data bit, MSB of PATTERN arrives first
//   pattern_detected_o - combinational match flag while the completing bit is on d_i
//   match_count_o      - saturating 8-bit count of detections (only with PD_MATCH_COUNT_EN)
//
// Optional feature: define PD_MATCH_COUNT_EN to add match_count_o.
module pattern_detect_mealy_fsm #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       d_i,
   output logic       pattern_detected_o
`ifdef PD_MATCH_COUNT_EN
   ,output logic [7:0] match_count_o
`endif
);
   localparam int SW = $clog2(PAT_LEN);
   localparam int NS = 2 ** SW;
   typedef logic [SW-1:0] state_t;
   // Longest prefix of PATTERN that is a proper suffix of (first k pattern bits, then b).
   // Capping at PAT_LEN-1 gives the overlap restart state after a full match.
   function automatic state_t next_of(input int k, input logic b);
      int  best;
      int  j;
      bit  ok;
      logic sb;
      best = 0;
      if (!OVERLAP && k == PAT_LEN - 1 && b == PATTERN[0]) return '0;
      for (int l = 1; l < PAT_LEN; l++) begin
         if (l <= k + 1) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
               j  = k + 1 - l + i;
               sb = (j == k) ? b : PATTERN[PAT_LEN-1-j];
               if (sb != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
            end
            if (ok) best = l;
         end
      end
      return state_t'(best);
   endfunction
   state_t state;
   state_t nx0 [NS];
   state_t nx1 [NS];
   // Transition table is constant; encodings beyond S(PAT_LEN-1) are unreachable and park in S0.
   for (genvar s = 0; s < NS; s++) begin : g_nx
      if (s < PAT_LEN) begin : g_v
         localparam state_t N0 = next_of(s, 1'b0);
         localparam state_t N1 = next_of(s, 1'b1);
         assign nx0[s] = N0;
         assign nx1[s] = N1;
      end else begin : g_u
         assign nx0[s] = '0;
         assign nx1[s] = '0;
      end
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= '0;
      else state <= d_i ? nx1[state] : nx0[state];
   assign pattern_detected_o = rst_i && state == state_t'(PAT_LEN - 1) && d_i == PATTERN[0];
`ifdef PD_MATCH_COUNT_EN
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) match_count_o <= '0;
      else if (pattern_detected_o && match_count_o != 8'hFF) match_count_o <= match_count_o + 8'd1;
`endif
endmodule

// File: tb/tb_pattern_detect_mealy_fsm.sv
// tb_pattern_detect_mealy_fsm: directed and random checks against a window-compare model
module tb_pattern_detect_mealy_fsm;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic d = 1'b0;
   logic pd1, pd0, pd2;
   int   tests = 0;
   int   fails = 0;
   int   lit1 = -1, lit0 = -1, lit2 = -1;
   bit   hist [$];
   int   last0 = -1000;
   int   cnt = 0;
`ifdef PD_MATCH_COUNT_EN
   logic [7:0] cnt1, cnt0_unused, cnt2_unused;
`endif
   always #5 clk = ~clk;
   pattern_detect_mealy_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .d_i(d), .pattern_detected_o(pd1)
`ifdef PD_MATCH_COUNT_EN
      , .match_count_o(cnt1)
`endif
   );
   pattern_detect_mealy_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_n (
      .clk_i(clk), .rst_i(rst), .d_i(d), .pattern_detected_o(pd0)
`ifdef PD_MATCH_COUNT_EN
      , .match_count_o(cnt0_unused)
`endif
   );
   pattern_detect_mealy_fsm #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) dut_1s (
      .clk_i(clk), .rst_i(rst), .d_i(d), .pattern_detected_o(pd2)
`ifdef PD_MATCH_COUNT_EN
      , .match_count_o(cnt2_unused)
`endif
   );
   // True when the last len bits since reset, ending with the bit now on d, spell p.
   function automatic bit window_hit(input logic [15:0] p, input int len);
      int n;
      int pos;
      bit b;
      n = hist.size();
      if (n < len - 1) return 1'b0;
      for (int i = 0; i < len; i++) begin
         pos = n - (len - 1) + i;
         b = (pos == n) ? d : hist[pos];
         if (b != p[len-1-i]) return 1'b0;
      end
      return 1'b1;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   always @(negedge clk) begin
      int n;
      bit x1, x0, x2;
      #2;
      if (!rst) begin
         hist.delete();
         last0 = -1000;
         cnt = 0;
      end
      n  = hist.size();
      x1 = rst && window_hit(16'b1011, 4);
      x0 = rst && window_hit(16'b1011, 4) && (n - last0 >= 4);
      x2 = rst && window_hit(16'b111, 3);
      check("det_ovl", int'(pd1), int'(x1));
      check("det_novl", int'(pd0), int'(x0));
      check("det_ones", int'(pd2), int'(x2));
      if (lit1 >= 0) check("lit_ovl", int'(pd1), lit1);
      if (lit0 >= 0) check("lit_novl", int'(pd0), lit0);
      if (lit2 >= 0) check("lit_ones", int'(pd2), lit2);
`ifdef PD_MATCH_COUNT_EN
      check("count", int'(cnt1), cnt);
`endif
      if (rst) begin
         if (x0) last0 = n;
         if (x1 && cnt < 255) cnt++;
         hist.push_back(d);
      end
   end
   task automatic step(input bit b, input bit r, input int e1, input int e0, input int e2);
      @(negedge clk);
      d = b;
      rst = r;
      lit1 = e1;
      lit0 = e0;
      lit2 = e2;
   endtask
   task automatic seq(input string bits, input string ex1, input string ex0, input string ex2);
      for (int i = 0; i < bits.len(); i++)
         step(bits[i] == "1", 1'b1,
              ex1[i] == "-" ? -1 : int'(ex1[i] == "1"),
              ex0[i] == "-" ? -1 : int'(ex0[i] == "1"),
              ex2[i] == "-" ? -1 : int'(ex2[i] == "1"));
   endtask
   initial begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      seq("1011", "0001", "0001", "----");
      step(0, 0, 0, 0, 0);
      seq("010110", "000010", "000010", "000000");
      step(0, 0, 0, 0, 0);
      seq("1011011", "0001001", "0001000", "-------");
      step(0, 0, 0, 0, 0);
      seq("11011", "00001", "00001", "00000");
      step(0, 0, 0, 0, 0);
      seq("101011", "000001", "000001", "------");
      step(0, 0, 0, 0, 0);
      seq("101", "000", "000", "000");
      step(1, 0, 0, 0, 0);
      seq("1", "0", "0", "0");
      seq("011", "001", "001", "000");
      step(0, 0, 0, 0, 0);
      seq("11111", "00000", "00000", "00111");
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 1'b1, -1, -1, -1);
         if (i == 150) step(1'b1, 1'b0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 270; i++) begin
         step(0, 1, 0, -1, 0);
         step(1, 1, 0, -1, 0);
         step(1, 1, 1, -1, 0);
      end
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      @(negedge clk);
      #4;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
